// File: rtl/dht11_uart_reporter.sv
// ---------------------------------------------------------------------------
// dht11_uart_reporter
//
// Takes one DHT11 measurement and sends it to a host PC as a fixed 17-byte
// ASCII line over a UART 8N1 transmit pin:
//
//     "T=ttt.f H=hhh.f" CR LF
//
// When the sensor reader pulses valid_in, the four measurement bytes are
// snapshotted. Both integer bytes then go through an 8-step shift-add-3
// binary-to-BCD conversion, running in parallel. After that the 17
// characters are sent back to back with no idle gap between frames.
//
// Ports:
//   clk         in   system clock, everything on the rising edge
//   rst         in   synchronous reset, active low
//   valid_in    in   one-cycle measurement-ready pulse
//   temp_int    in   temperature integer part (unsigned)
//   temp_dec    in   temperature decimal part (shown as min(value, 9))
//   hum_int     in   humidity integer part (unsigned)
//   hum_dec     in   humidity decimal part (shown as min(value, 9))
//   uart_tx     out  serial output, idle high, driven from a register
//   busy        out  high from acceptance until the last stop bit ends
//   drop_count  out  saturating count of valid_in pulses ignored while busy
// ---------------------------------------------------------------------------
module dht11_uart_reporter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    output logic       uart_tx,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [4:0] LAST_CHAR = 5'd16;

    logic [1:0]       state_q,   state_d;
    logic [2:0]       convCnt_q, convCnt_d;
    logic [11:0]      tBcd_q,    tBcd_d;
    logic [7:0]       tBin_q,    tBin_d;
    logic [11:0]      hBcd_q,    hBcd_d;
    logic [7:0]       hBin_q,    hBin_d;
    logic [3:0]       tFrac_q,   tFrac_d;
    logic [3:0]       hFrac_q,   hFrac_d;
    logic [4:0]       charIdx_q, charIdx_d;
    logic [3:0]       bitIdx_q,  bitIdx_d;
    logic [CNT_W-1:0] clkCnt_q,  clkCnt_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             frameOn_q, frameOn_d;
    logic             lead_q,    lead_d;
    logic [7:0]       drop_q,    drop_d;

    // A decimal byte is shown as a single digit, so anything above 9
    // is clamped to 9.
    function automatic logic [3:0] clampDigit(input logic [7:0] v);
        return (v > 8'd9) ? 4'd9 : v[3:0];
    endfunction

    // Add 3 to a BCD digit of 5 or more before the shift, so that the
    // digit carries correctly into the next decade when doubled.
    function automatic logic [3:0] addThree(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One shift-add-3 step. The result is packed as {bcd[11:0], bin[7:0]}.
    function automatic logic [19:0] ddStep(input logic [11:0] bcd,
                                           input logic [7:0]  bin);
        logic [11:0] adj;
        adj = {addThree(bcd[11:8]), addThree(bcd[7:4]), addThree(bcd[3:0])};
        return {adj[10:0], bin, 1'b0};
    endfunction

    function automatic logic [7:0] asciiDigit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Character at position idx of the output line.
    function automatic logic [7:0] charAt(input logic [4:0]  idx,
                                          input logic [11:0] tBcd,
                                          input logic [11:0] hBcd,
                                          input logic [3:0]  tFrac,
                                          input logic [3:0]  hFrac);
        logic [7:0] c;
        case (idx)
            5'd0:    c = "T";
            5'd1:    c = "=";
            5'd2:    c = asciiDigit(tBcd[11:8]);
            5'd3:    c = asciiDigit(tBcd[7:4]);
            5'd4:    c = asciiDigit(tBcd[3:0]);
            5'd5:    c = ".";
            5'd6:    c = asciiDigit(tFrac);
            5'd7:    c = " ";
            5'd8:    c = "H";
            5'd9:    c = "=";
            5'd10:   c = asciiDigit(hBcd[11:8]);
            5'd11:   c = asciiDigit(hBcd[7:4]);
            5'd12:   c = asciiDigit(hBcd[3:0]);
            5'd13:   c = ".";
            5'd14:   c = asciiDigit(hFrac);
            5'd15:   c = 8'h0D;
            5'd16:   c = 8'h0A;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // Next-state logic for the FSM, the converter, the UART framer and
    // the drop counter.
    always_comb begin
        state_d   = state_q;
        convCnt_d = convCnt_q;
        tBcd_d    = tBcd_q;
        tBin_d    = tBin_q;
        hBcd_d    = hBcd_q;
        hBin_d    = hBin_q;
        tFrac_d   = tFrac_q;
        hFrac_d   = hFrac_q;
        charIdx_d = charIdx_q;
        bitIdx_d  = bitIdx_q;
        clkCnt_d  = clkCnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        frameOn_d = frameOn_q;
        lead_d    = lead_q;
        drop_d    = drop_q;

        // A pulse that arrives while a line is in progress is only counted.
        // This includes the cycle in which the last stop bit ends.
        if (valid_in && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (valid_in) begin
                    state_d   = ST_CONV;
                    convCnt_d = 3'd0;
                    tBin_d    = temp_int;
                    hBin_d    = hum_int;
                    tBcd_d    = 12'd0;
                    hBcd_d    = 12'd0;
                    tFrac_d   = clampDigit(temp_dec);
                    hFrac_d   = clampDigit(hum_dec);
                end
            end

            ST_CONV: begin
                {tBcd_d, tBin_d} = ddStep(tBcd_q, tBin_q);
                {hBcd_d, hBin_d} = ddStep(hBcd_q, hBin_q);
                convCnt_d        = convCnt_q + 3'd1;
                if (convCnt_q == 3'd7) begin
                    state_d   = ST_SEND;
                    charIdx_d = 5'd0;
                    frameOn_d = 1'b0;
                    lead_d    = 1'b1;
                end
            end

            ST_SEND: begin
                if (!frameOn_q) begin
                    // One spare cycle after conversion places the first
                    // start bit exactly ten cycles after acceptance.
                    if (lead_q) begin
                        lead_d = 1'b0;
                    end else begin
                        frameOn_d = 1'b1;
                        tx_d      = 1'b0;
                        shift_d   = charAt(charIdx_q, tBcd_q, hBcd_q, tFrac_q, hFrac_q);
                        bitIdx_d  = 4'd0;
                        clkCnt_d  = '0;
                    end
                end else if (clkCnt_q != LAST_CLK) begin
                    clkCnt_d = clkCnt_q + CNT_W'(1);
                end else begin
                    clkCnt_d = '0;
                    // bitIdx: 0 = start, 1..8 = data LSB first, 9 = stop
                    if (bitIdx_q < 4'd8) begin
                        tx_d     = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitIdx_d = bitIdx_q + 4'd1;
                    end else if (bitIdx_q == 4'd8) begin
                        tx_d     = 1'b1;
                        bitIdx_d = 4'd9;
                    end else if (charIdx_q == LAST_CHAR) begin
                        state_d   = ST_IDLE;
                        frameOn_d = 1'b0;
                        tx_d      = 1'b1;
                    end else begin
                        // The next start bit follows the stop bit directly.
                        charIdx_d = charIdx_q + 5'd1;
                        tx_d      = 1'b0;
                        shift_d   = charAt(charIdx_q + 5'd1, tBcd_q, hBcd_q, tFrac_q, hFrac_q);
                        bitIdx_d  = 4'd0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers. A reset abandons any partial frame right away.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            convCnt_q <= 3'd0;
            tBcd_q    <= 12'd0;
            tBin_q    <= 8'd0;
            hBcd_q    <= 12'd0;
            hBin_q    <= 8'd0;
            tFrac_q   <= 4'd0;
            hFrac_q   <= 4'd0;
            charIdx_q <= 5'd0;
            bitIdx_q  <= 4'd0;
            clkCnt_q  <= '0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            frameOn_q <= 1'b0;
            lead_q    <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            convCnt_q <= convCnt_d;
            tBcd_q    <= tBcd_d;
            tBin_q    <= tBin_d;
            hBcd_q    <= hBcd_d;
            hBin_q    <= hBin_d;
            tFrac_q   <= tFrac_d;
            hFrac_q   <= hFrac_d;
            charIdx_q <= charIdx_d;
            bitIdx_q  <= bitIdx_d;
            clkCnt_q  <= clkCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            frameOn_q <= frameOn_d;
            lead_q    <= lead_d;
            drop_q    <= drop_d;
        end
    end

    assign uart_tx    = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign drop_count = drop_q;

endmodule
